fifo_puerto: RTL and testbench
==============================

FIFO_PUERTO -- requirements
Module: fifo_puerto

Interface
REQ-001 The block SHALL have the parameter FIFO_WORD_SIZE, default 10, giving the data word width in bits.
REQ-002 The block SHALL have the parameter FIFO_DEPTH, default 8, giving the number of words stored; it SHALL be a power of 2.
REQ-003 The block SHALL have the parameter PTR_SIZE, default 3, equal to log2(FIFO_DEPTH).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_L  input  1  reset, synchronous and active-low.
REQ-006 push  input  1  write request from the upstream producer.
REQ-007 pop  input  1  read request from the downstream arbiter.
REQ-008 data_in  input  FIFO_WORD_SIZE  word to write.
REQ-009 umbral_af  input  PTR_SIZE+1  almost-full threshold, in words.
REQ-010 umbral_ae  input  PTR_SIZE+1  almost-empty threshold, in words.
REQ-011 data_out  output  FIFO_WORD_SIZE  head word, first-word-fall-through.
REQ-012 empty  output  1  high when the occupancy is 0.
REQ-013 full  output  1  high when the occupancy is FIFO_DEPTH.
REQ-014 almostfull  output  1  high when the occupancy is >= umbral_af.
REQ-015 almostempty  output  1  high when the occupancy is <= umbral_ae.
REQ-016 error  output  1  sticky overflow/underflow flag.
REQ-017 count  output  PTR_SIZE+1  current occupancy.

Function
REQ-018 Storage SHALL be FIFO_DEPTH x FIFO_WORD_SIZE registers, addressed by wr_ptr and rd_ptr (PTR_SIZE bits each), with an occupancy register count.
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH: 7 -> 0 at the default depth.
REQ-020 A write SHALL be accepted when push=1 and (full=0 or pop=1): mem[wr_ptr] <= data_in and wr_ptr increments at the same edge.
REQ-021 A read SHALL be accepted when pop=1 and empty=0: rd_ptr increments at that edge.
REQ-022 data_out SHALL equal mem[rd_ptr] combinationally when empty=0, and 0 when empty=0 is false (FIFO empty); the consumer samples data_out in the same cycle it asserts pop.
REQ-023 count SHALL update as follows: +1 on an accepted write only, -1 on an accepted read only, and unchanged when both or neither are accepted.
REQ-024 On full with push=1 and pop=1, both operations SHALL be accepted, the pointers SHALL advance, and count SHALL stay at FIFO_DEPTH.
REQ-025 On empty with push=1 and pop=1, only the write SHALL be accepted, count SHALL go from 0 to 1, and error SHALL be set.
REQ-026 A push while full without pop (overflow) SHALL be dropped: no pointer or memory change, and error set.
REQ-027 A pop while empty (underflow) SHALL be ignored, and error set.
REQ-028 error SHALL remain 1 until reset.
REQ-029 empty, full, almostfull and almostempty SHALL be derived combinationally from the registered count, so they reflect an operation in the cycle after its edge.
REQ-030 Thresholds SHALL be compared unsigned.
REQ-031 umbral_af=0 SHALL force almostfull=1.
REQ-032 umbral_ae >= FIFO_DEPTH SHALL force almostempty=1.
REQ-033 Flags SHALL follow threshold changes immediately.
REQ-034 No path other than the memory write SHALL depend on data_in.

Reset
REQ-035 While reset_L=0 at a rising edge, the block SHALL force wr_ptr=0, rd_ptr=0, count=0 and error=0; memory contents need not be cleared.
REQ-036 After reset the outputs SHALL be: empty=1, full=0, almostfull=(umbral_af==0), almostempty=1, data_out=0, count=0.
REQ-037 Reset SHALL take priority over push/pop in the same cycle; a reset mid-operation SHALL discard all stored words.

Verification
REQ-038 Fill/drain: after reset, push 0x001..0x008 on 8 consecutive cycles -> full=1 and count=8 the cycle after the last push; pop 8 cycles -> data_out reads 0x001..0x008 in order, then empty=1 and error=0.
REQ-039 Wrap-around: push 5 words, pop 5, push 6 (0x100..0x105) -> wr_ptr crosses 7 -> 0, and the pops return 0x100..0x105 in order.
REQ-040 Overflow/simultaneous: when full, push 0x3FF with pop=0 -> count stays 8 and error=1; then push 0x2AA with pop=1 -> the head is consumed, count stays 8, and 0x2AA is read last.
REQ-041 Underflow: when empty, pop=1 with push=1 and data_in=0x055 -> count=1, data_out=0x055, error=1.
REQ-042 Thresholds: with umbral_af=6 and umbral_ae=2, push 1 word per cycle -> almostempty=1 for counts 0-2, almostfull rises when count=6, and almostfull falls on the pop that takes count to 5.
REQ-043 Reset mid-operation: with 4 words stored and error=1, drive reset_L=0 for 1 cycle with push=1 -> count=0, empty=1, error=0, data_out=0; the pushed word is not stored.

Source files
------------

// File: rtl/fifo_puerto.sv
//------------------------------------------------------------------------------
// fifo_puerto: register-based first-word-fall-through FIFO for one port, with
//              programmable almost-full/almost-empty thresholds and a sticky error.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_puerto #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int FIFO_DEPTH     = 8,
  parameter int PTR_SIZE       = 3
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      push,
  input  logic                      pop,
  input  logic [FIFO_WORD_SIZE-1:0] data_in,
  input  logic [PTR_SIZE:0]         umbral_af,
  input  logic [PTR_SIZE:0]         umbral_ae,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almostfull,
  output logic                      almostempty,
  output logic                      error,
  output logic [PTR_SIZE:0]         count
);

  localparam logic [PTR_SIZE:0]   c_depth   = FIFO_DEPTH[PTR_SIZE:0];
  localparam logic [PTR_SIZE:0]   c_cnt_one = {{PTR_SIZE{1'b0}}, 1'b1};
  localparam logic [PTR_SIZE-1:0] c_ptr_one = {{(PTR_SIZE-1){1'b0}}, 1'b1};

  logic [FIFO_WORD_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_SIZE-1:0]       r_wr_ptr;
  logic [PTR_SIZE-1:0]       r_rd_ptr;
  logic [PTR_SIZE:0]         r_count;
  logic                      r_error;

  logic w_wr_en;
  logic w_rd_en;
  logic w_fault;

  // A pop frees a slot in the same edge, so a full FIFO still accepts push+pop.
  assign w_wr_en = push & (~full | pop);
  assign w_rd_en = pop & ~empty;
  assign w_fault = (push & full & ~pop) | (pop & empty);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= data_in;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_wr_en && !w_rd_en) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_rd_en && !w_wr_en) begin
        r_count <= r_count - c_cnt_one;
      end
      if (w_fault) begin
        r_error <= 1'b1;
      end
    end
  end

  // Status is decoded from the registered occupancy only; thresholds act live.
  always_comb begin
    count       = r_count;
    error       = r_error;
    empty       = (r_count == '0);
    full        = (r_count == c_depth);
    almostfull  = (r_count >= umbral_af);
    almostempty = (r_count <= umbral_ae);
    data_out    = empty ? '0 : r_mem[r_rd_ptr];
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_puerto.sv
//------------------------------------------------------------------------------
// tb_fifo_puerto: vector table, directed corner sequences and random traffic
//                 checked against a queue-based reference model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_puerto;

  localparam int W = 10;
  localparam int D = 8;
  localparam int P = 3;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [P:0]   umbral_af = 4'd6;
  logic [P:0]   umbral_ae = 4'd2;
  logic [W-1:0] data_out;
  logic         empty, full, almostfull, almostempty, error;
  logic [P:0]   count;

  fifo_puerto #(.FIFO_WORD_SIZE(W), .FIFO_DEPTH(D), .PTR_SIZE(P)) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
    .umbral_af(umbral_af), .umbral_ae(umbral_ae), .data_out(data_out),
    .empty(empty), .full(full), .almostfull(almostfull),
    .almostempty(almostempty), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of stored words plus a sticky error bit.
  logic [W-1:0] mq[$];
  bit           m_err = 1'b0;

  typedef struct {
    bit           rst_n, ps, pp;
    logic [W-1:0] d;
    int           cnt;
    bit           emp, ful, af, ae, err;
    logic [W-1:0] dout;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(bit r, bit p, bit q, int d, int c, bit e, bit f,
                              bit af, bit ae, bit er, int dout);
    vec_t v;
    v.rst_n = r; v.ps = p; v.pp = q; v.d = d[W-1:0]; v.cnt = c;
    v.emp = e; v.ful = f; v.af = af; v.ae = ae; v.err = er; v.dout = dout[W-1:0];
    tbl.push_back(v);
  endfunction

  function automatic void model_step(bit r, bit p, bit q, logic [W-1:0] d);
    bit wr, rd;
    if (!r) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      wr = p && (mq.size() < D || q);
      rd = q && mq.size() > 0;
      if ((p && !q && mq.size() == D) || (q && mq.size() == 0)) m_err = 1'b1;
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(d);
    end
  endfunction

  task automatic check_model(string tag);
    int sz = mq.size();
    chk({tag, ".count"}, 32'(count), 32'(sz));
    chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    chk({tag, ".full"}, 32'(full), 32'(sz == D));
    chk({tag, ".almostfull"}, 32'(almostfull), 32'(sz >= int'(umbral_af)));
    chk({tag, ".almostempty"}, 32'(almostempty), 32'(sz <= int'(umbral_ae)));
    chk({tag, ".error"}, 32'(error), 32'(m_err));
    chk({tag, ".data_out"}, 32'(data_out), sz > 0 ? 32'(mq[0]) : 32'd0);
  endtask

  // Drive one cycle; the head word is checked before the edge that consumes it.
  task automatic cycle(string tag, bit r, bit p, bit q, logic [W-1:0] d);
    reset_L = r; push = p; pop = q; data_in = d;
    #1;
    if (r && q && mq.size() > 0) chk({tag, ".head"}, 32'(data_out), 32'(mq[0]));
    @(posedge clk);
    #1;
    model_step(r, p, q, d);
    check_model(tag);
  endtask

  initial begin
    // Fill, overflow, push+pop on full, drain, then push+pop on empty.
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) add(1, 1, 0, i, i, 0, i == 8, i >= 6, i <= 2, 0, 1);
    add(1, 1, 0, 'h3FF, 8, 0, 1, 1, 0, 1, 1);
    add(1, 1, 1, 'h2AA, 8, 0, 1, 1, 0, 1, 2);
    for (int j = 1; j <= 7; j++)
      add(1, 0, 1, 0, 8 - j, 0, 0, (8 - j) >= 6, (8 - j) <= 2, 1, j <= 6 ? j + 2 : 'h2AA);
    add(1, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0);
    add(1, 1, 1, 'h055, 1, 0, 0, 0, 1, 1, 'h055);

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(t, tbl[i].rst_n, tbl[i].ps, tbl[i].pp, tbl[i].d);
      chk({t, ".tbl_count"}, 32'(count), 32'(tbl[i].cnt));
      chk({t, ".tbl_empty"}, 32'(empty), 32'(tbl[i].emp));
      chk({t, ".tbl_full"}, 32'(full), 32'(tbl[i].ful));
      chk({t, ".tbl_af"}, 32'(almostfull), 32'(tbl[i].af));
      chk({t, ".tbl_ae"}, 32'(almostempty), 32'(tbl[i].ae));
      chk({t, ".tbl_error"}, 32'(error), 32'(tbl[i].err));
      chk({t, ".tbl_dout"}, 32'(data_out), 32'(tbl[i].dout));
    end

    // Underflow with simultaneous push from a clean reset.
    cycle("uf_rst", 0, 0, 0, 0);
    cycle("uf", 1, 1, 1, 'h055);
    chk("uf.error_set", 32'(error), 32'd1);
    chk("uf.dout_055", 32'(data_out), 32'h055);

    // Wrap-around: write pointer crosses the end of storage.
    cycle("wr_rst", 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle("wr_a", 1, 1, 0, 10'(i + 'h20));
    for (int i = 0; i < 5; i++) cycle("wr_b", 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) cycle("wr_c", 1, 1, 0, 10'(i + 'h100));
    for (int i = 0; i < 6; i++) begin
      #0 chk($sformatf("wrap.read%0d", i), 32'(data_out), 32'('h100 + i));
      cycle("wr_d", 1, 0, 1, 0);
    end

    // Reset mid-operation with a word pushed during reset.
    cycle("rm_uf", 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle("rm_fill", 1, 1, 0, 10'(i + 'h40));
    chk("rm.error_pre", 32'(error), 32'd1);
    cycle("rm_rst", 0, 1, 0, 'h1AB);
    chk("rm.count0", 32'(count), 32'd0);
    chk("rm.error0", 32'(error), 32'd0);
    chk("rm.dout0", 32'(data_out), 32'd0);
    cycle("rm_idle", 1, 0, 0, 0);
    chk("rm.not_stored", 32'(count), 32'd0);

    // Threshold extremes, applied without a clock edge.
    umbral_af = 4'd0; #1;
    chk("th.af0_empty", 32'(almostfull), 32'd1);
    umbral_ae = 4'd15;
    for (int i = 0; i < 8; i++) cycle("th_fill", 1, 1, 0, 10'(i));
    chk("th.ae15_full", 32'(almostempty), 32'd1);
    umbral_ae = 4'd8; #1;
    chk("th.ae8_full", 32'(almostempty), 32'd1);
    umbral_ae = 4'd7; umbral_af = 4'd9; #1;
    chk("th.ae7_full", 32'(almostempty), 32'd0);
    chk("th.af9_full", 32'(almostfull), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      bit r, p, q;
      r = ($urandom_range(0, 99) != 0);
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 19) == 0) begin
        umbral_af = 4'($urandom_range(0, 15));
        umbral_ae = 4'($urandom_range(0, 15));
      end
      cycle("rnd", r, p, q, 10'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
